// File: rtl/alu_tv_writer.sv
// Captures ALU ops as 104-bit vector words into a DEPTH-entry buffer, then streams them out in capture order.
// Latency: first out_valid 2 cycles after dump_start, then 1 word/cycle; out_word holds while !out_ready, cap_ready drops when full.
module alu_tv_writer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cap_valid,
  output logic          cap_ready,
  input  logic [2:0]    f,
  input  logic [31:0]   a,
  input  logic [31:0]   b,
  input  logic [31:0]   y,
  input  logic          dump_start,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [103:0]  out_word,
  output logic [AW:0]   count,
  output logic          full,
  output logic          done
);

  typedef enum logic [1:0] {ST_CAPTURE, ST_DUMP, ST_DONE} state_t;

  typedef struct packed {
    logic [2:0]  pad_hi;
    logic        zero;
    logic        pad_lo;
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
  } tv_word_t;

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  state_t          state_q, state_d;
  logic [AW:0]     count_q, count_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            out_vld_q, out_vld_d;
  tv_word_t        out_dat_q, out_dat_d;
  tv_word_t        mem_q [DEPTH];

  logic            cap_rdy;
  logic            cap_fire;
  logic            wr_en;
  tv_word_t        wr_dat;
  logic            out_fire;
  logic            last_word;
  logic            rd_en;
  logic [AW-1:0]   rd_addr;

  assign cap_rdy   = (state_q == ST_CAPTURE) && (count_q != DEPTH_C);
  assign cap_fire  = cap_valid && cap_rdy;
  assign wr_en     = cap_fire && !reset;
  assign out_fire  = out_vld_q && out_ready;
  assign last_word = ({1'b0, rd_ptr_q} == (count_q - 1'b1));

  always_comb begin
    wr_dat        = '0;
    wr_dat.zero   = (y == 32'h0);
    wr_dat.f      = f;
    wr_dat.a      = a;
    wr_dat.b      = b;
    wr_dat.y      = y;
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    rd_ptr_d  = rd_ptr_q;
    out_vld_d = out_vld_q;
    rd_en     = 1'b0;
    rd_addr   = rd_ptr_q;
    case (state_q)
      ST_CAPTURE: begin
        if (cap_fire) count_d = count_q + 1'b1;
        // Using count_d lets a same-cycle capture join the dump it triggers.
        if (dump_start) begin
          rd_ptr_d = '0;
          state_d  = (count_d == '0) ? ST_DONE : ST_DUMP;
        end
      end
      ST_DUMP: begin
        if (!out_vld_q) begin
          rd_en     = 1'b1;
          out_vld_d = 1'b1;
        end else if (out_fire) begin
          if (last_word) begin
            out_vld_d = 1'b0;
            state_d   = ST_DONE;
          end else begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            rd_addr  = rd_ptr_q + 1'b1;
            rd_en    = 1'b1;
          end
        end
      end
      ST_DONE: begin
        count_d  = '0;
        rd_ptr_d = '0;
        state_d  = ST_CAPTURE;
      end
      default: state_d = ST_CAPTURE;
    endcase
    out_dat_d = rd_en ? mem_q[rd_addr] : out_dat_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_CAPTURE;
      count_q   <= '0;
      rd_ptr_q  <= '0;
      out_vld_q <= 1'b0;
      out_dat_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      rd_ptr_q  <= rd_ptr_d;
      out_vld_q <= out_vld_d;
      out_dat_q <= out_dat_d;
    end
  end

  // Buffer contents survive reset; only the occupancy is cleared.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[count_q[AW-1:0]] <= wr_dat;
  end

  assign cap_ready = cap_rdy;
  assign out_valid = out_vld_q;
  assign out_word  = out_dat_q;
  assign count     = count_q;
  assign full      = (count_q == DEPTH_C);
  assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_alu_tv_writer.sv
// Scoreboard bench for alu_tv_writer: expected words queued at capture, compared as they stream out.
module tb_alu_tv_writer;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cap_valid = 1'b0;
  logic          cap_ready;
  logic [2:0]    f = '0;
  logic [31:0]   a = '0;
  logic [31:0]   b = '0;
  logic [31:0]   y = '0;
  logic          dump_start = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [103:0]  out_word;
  logic [4:0]    count;
  logic          full;
  logic          done;

  int            n_cmp = 0;
  int            n_err = 0;
  int            mcount = 0;
  logic [103:0]  sb [$];

  alu_tv_writer #(.DEPTH(16), .AW(4)) dut (
    .clk(clk), .reset(reset), .cap_valid(cap_valid), .cap_ready(cap_ready),
    .f(f), .a(a), .b(b), .y(y), .dump_start(dump_start),
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
    .count(count), .full(full), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [103:0] act, input logic [103:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cap(input logic [2:0] tf, input logic [31:0] ta, input logic [31:0] tb_,
                     input logic [31:0] ty, input bit with_dump);
    logic [103:0] w;
    f = tf; a = ta; b = tb_; y = ty;
    cap_valid  = 1'b1;
    dump_start = with_dump;
    chk("cap_ready", cap_ready, mcount < 16);
    if (mcount < 16) begin
      w = {3'b000, (ty == 32'h0), 1'b0, tf, ta, tb_, ty};
      sb.push_back(w);
      mcount++;
    end
    step();
    cap_valid  = 1'b0;
    dump_start = 1'b0;
    if (!with_dump) begin
      chk("count", count, mcount);
      chk("full", full, mcount == 16);
    end
  endtask

  task automatic run_dump(input string tag, input logic [3:0] pat, input bit empty, input bit started);
    bit           got_done;
    bit           held;
    logic [103:0] held_w;
    int           k;
    got_done = 0; held = 0; held_w = '0; k = 0;
    if (!started) begin
      dump_start = 1'b1;
      step();
      dump_start = 1'b0;
    end
    chk("lat_first_cycle_vld", out_valid, 0);
    if (empty) begin
      chk("empty_done", done, 1);
      got_done = 1;
    end else begin
      step();
      chk("lat_second_cycle_vld", out_valid, 1);
      for (int c = 0; c < 400 && !got_done; c++) begin
        if (done) begin
          got_done = 1;
          chk("sb_drained", sb.size(), 0);
          chk("vld_at_done", out_valid, 0);
        end else begin
          if (held) begin
            chk("hold_vld", out_valid, 1);
            chk("hold_word", out_word, held_w);
          end
          if (out_valid) begin
            out_ready = pat[k % 4];
            k++;
            if (out_ready) begin
              if (sb.size() == 0) chk("extra_word", 1, 0);
              else chk(tag, out_word, sb.pop_front());
              held = 0;
            end else begin
              held   = 1;
              held_w = out_word;
            end
          end else begin
            out_ready = 1'b0;
          end
          step();
        end
      end
    end
    out_ready = 1'b0;
    if (!got_done) chk("done_timeout", 0, 1);
    step();
    chk("done_one_cycle", done, 0);
    chk("count_cleared", count, 0);
    chk("back_to_capture", cap_ready, 1);
    mcount = 0;
    sb.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step();
    step();
    reset = 1'b0;
    chk("rst_cap_ready", cap_ready, 1);
    chk("rst_count", count, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_word", out_word, 0);
    chk("rst_done", done, 0);
    chk("rst_full", full, 0);

    // 1: single word
    cap(3'd2, 32'd5, 32'd3, 32'd8, 0);
    sb[sb.size()-1] = 104'h0_2_00000005_00000003_00000008;
    run_dump("t1_word", 4'hF, 0, 0);

    // 2: zero flag
    cap(3'd6, 32'd3, 32'd3, 32'd0, 0);
    sb[sb.size()-1] = 104'h1_6_00000003_00000003_00000000;
    run_dump("t2_word", 4'hF, 0, 0);

    // 3: fill, drop 17th, dump all
    for (int i = 0; i < 16; i++)
      cap(3'($urandom_range(0, 7)), $urandom, $urandom, (i % 5 == 0) ? 32'h0 : $urandom, 0);
    chk("full_flag", full, 1);
    cap(3'd1, 32'hDEAD_BEEF, 32'h1, 32'h2, 0);
    run_dump("t3_word", 4'hF, 0, 0);

    // 4: stalling sink
    for (int i = 0; i < 6; i++)
      cap(3'(i), 32'h100 + i, 32'h200 + i, 32'h300 + i, 0);
    run_dump("t4_word", 4'b1001, 0, 0);

    // 5: empty dump
    run_dump("t5_word", 4'hF, 1, 0);

    // capture in the same cycle as dump_start is included
    cap(3'd3, 32'h11, 32'h22, 32'h33, 0);
    cap(3'd4, 32'h44, 32'h55, 32'h66, 1);
    run_dump("same_cycle_word", 4'hF, 0, 1);

    // 6: reset mid-dump
    for (int i = 0; i < 8; i++)
      cap(3'd7, $urandom, $urandom, $urandom, 0);
    dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    step();
    chk("t6_vld", out_valid, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("t6_word", out_word, sb.pop_front());
      step();
    end
    reset = 1'b1;
    out_ready = 1'b0;
    step();
    chk("t6_out_valid", out_valid, 0);
    chk("t6_count", count, 0);
    chk("t6_cap_ready", cap_ready, 1);
    chk("t6_done", done, 0);
    reset = 1'b0;
    sb.delete();
    mcount = 0;
    step();
    cap(3'd5, 32'hA5A5_0001, 32'h5A5A_0002, 32'h0, 0);
    run_dump("t6_after_word", 4'hF, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
